// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cpu_pkg
//  Brief  : Shared ALU opcodes, arbiter state encoding and opcode helper.
//           Contents:
//             ALU_OP_W, ALU_OP_ADD, ALU_OP_SUB  opcode width / legal opcodes
//             arb_state_e                       alu_arbiter FSM states
//             is_legal_op()                     1 when opcode is ADD or SUB
//  Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int              ALU_OP_W   = 6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 6'b100000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 6'b100010;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  // The ALU only implements ADD and SUB; anything else returns 0.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module : rr_arb2
//  Brief  : Two-way round-robin grant, purely combinational. The caller owns
//           the priority pointer and advances it after each grant.
//  Ports  : req[1:0]  in   request lines
//           pointer   in   requester currently holding priority
//           gnt[1:0]  out  one-hot grant (all zero when no request)
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (pointer == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : alu_arbiter
//  Brief  : Shares one combinational ALU between requester 0 (execute) and
//           requester 1 (address/branch). Round-robin grant, registered result
//           returned on a single valid/ready response bus tagged with the id.
//  Ports  : clk, rst (async, active-low)
//           reqN_valid/ready/in1/in2/op   requester N issue interface (N=0,1)
//           rsp_valid/ready/id/data/zero/err  registered response
//           alu_in1/in2/opcode -> alu, alu_out/alu_zero <- alu
//           op_count  responses accepted by the consumer, wraps
//  Rev    : 1.0  initial release
// ============================================================================
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_in1,
  input  logic [WIDTH-1:0]    req0_in2,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_in1,
  input  logic [WIDTH-1:0]    req1_in2,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [WIDTH-1:0]    alu_in1,
  output logic [WIDTH-1:0]    alu_in2,
  output logic [ALU_OP_W-1:0] alu_opcode,
  input  logic [WIDTH-1:0]    alu_out,
  input  logic                alu_zero,
  output logic [CNT_W-1:0]    op_count
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [1:0]       arb_req;
  logic [1:0]       gnt;

  // Requests are only presented to the arbiter while IDLE, so readiness is a
  // function of state and valids alone and never of rsp_ready.
  assign arb_req = (state_q == ARB_IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req     (arb_req),
    .pointer (ptr_q),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // ALU operand mux; zero when nobody is granted.
  always_comb begin
    alu_in1    = '0;
    alu_in2    = '0;
    alu_opcode = '0;
    if (gnt[0]) begin
      alu_in1    = req0_in1;
      alu_in2    = req0_in2;
      alu_opcode = req0_op;
    end else if (gnt[1]) begin
      alu_in1    = req1_in1;
      alu_in2    = req1_in2;
      alu_opcode = req1_op;
    end
  end

  // Next-state / response register logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt != 2'b00) begin
          rsp_data_d  = alu_out;
          rsp_zero_d  = alu_zero;
          rsp_id_d    = gnt[1];
          rsp_err_d   = ~is_legal_op(alu_opcode);
          rsp_valid_d = 1'b1;
          // Loser of a tie holds priority next time.
          ptr_d       = ~gnt[1];
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_arbiter
//  Brief  : Self-checking bench for alu_arbiter with a behavioural ALU and a
//           transaction-level reference model (pending-response slot, priority
//           bit, counter). Directed scenarios followed by random traffic.
//           The counter is built 8 bits wide so the wrap is reachable quickly.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [5:0]    req0_op = '0, req1_op = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0]  rsp_data;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic [5:0]    alu_opcode;
  logic          alu_zero;
  logic [CW-1:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .op_count(op_count)
  );

  // Reference ALU behaviour: ADD, SUB, everything else 0.
  function automatic logic [W-1:0] ref_alu(input logic [5:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (op == 6'b100000) return a + b;
    if (op == 6'b100010) return a - b;
    return '0;
  endfunction

  // Behavioural ALU instance seen by the DUT.
  always_comb begin
    alu_out  = ref_alu(alu_opcode, alu_in1, alu_in2);
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One pending-response slot; a new request is accepted only when it is empty.
  bit            m_busy, m_ptr, p_id, p_zero, p_err;
  logic [W-1:0]  p_data;
  logic [CW-1:0] m_cnt;
  bit            n_busy, n_ptr, n_id, n_zero, n_err_f;
  logic [W-1:0]  n_data;
  logic [CW-1:0] n_cnt;

  always @(negedge clk) begin
    if (rst) begin
      int       g;
      logic [W-1:0] a, b, d;
      logic [5:0]   op;
      g = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) g = m_ptr ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      a  = (g == 0) ? req0_in1 : (g == 1) ? req1_in1 : '0;
      b  = (g == 0) ? req0_in2 : (g == 1) ? req1_in2 : '0;
      op = (g == 0) ? req0_op  : (g == 1) ? req1_op  : '0;
      chk("req0_ready", 64'(req0_ready), 64'(g == 0));
      chk("req1_ready", 64'(req1_ready), 64'(g == 1));
      chk("alu_in1", 64'(alu_in1), 64'(a));
      chk("alu_in2", 64'(alu_in2), 64'(b));
      chk("alu_opcode", 64'(alu_opcode), 64'(op));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_busy));
      chk("op_count", 64'(op_count), 64'(m_cnt));
      if (m_busy) begin
        chk("rsp_id", 64'(rsp_id), 64'(p_id));
        chk("rsp_data", 64'(rsp_data), 64'(p_data));
        chk("rsp_zero", 64'(rsp_zero), 64'(p_zero));
        chk("rsp_err", 64'(rsp_err), 64'(p_err));
      end
      // Effect of the coming clock edge.
      n_busy = m_busy; n_ptr = m_ptr; n_cnt = m_cnt;
      n_id = p_id; n_data = p_data; n_zero = p_zero; n_err_f = p_err;
      if (g >= 0) begin
        d       = ref_alu(op, a, b);
        n_busy  = 1'b1;
        n_id    = (g == 1);
        n_data  = d;
        n_zero  = (d == '0);
        n_err_f = !(op == 6'b100000 || op == 6'b100010);
        n_ptr   = (g == 0);
      end else if (m_busy && rsp_ready) begin
        n_busy = 1'b0;
        n_cnt  = m_cnt + 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = '0;
      p_id = 0; p_data = '0; p_zero = 0; p_err = 0;
      n_busy = 0; n_ptr = 0; n_cnt = '0;
      n_id = 0; n_data = '0; n_zero = 0; n_err_f = 0;
    end else begin
      m_busy = n_busy; m_ptr = n_ptr; m_cnt = n_cnt;
      p_id = n_id; p_data = n_data; p_zero = n_zero; p_err = n_err_f;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [5:0] op);
    if (n == 0) begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_op = op;
    end else begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_op = op;
    end
  endtask

  initial begin
    int guard;
    // 1. Reset state
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_in1", 64'(alu_in1), 64'd0);
    tick(); tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_op_count", 64'(op_count), 64'd0);

    // 2. Single ADD from requester 0
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd7, ALU_OP_ADD);
    #2;
    chk("add_req0_ready", 64'(req0_ready), 64'd1);
    chk("add_alu_in1", 64'(alu_in1), 64'd5);
    tick();
    req0_valid = 1'b0;
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_rsp_id", 64'(rsp_id), 64'd0);
    chk("add_rsp_data", 64'(rsp_data), 64'd12);
    chk("add_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("add_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    chk("add_op_count", 64'(op_count), 64'd1);

    // Requester 1 alone, returns priority to requester 0.
    set_req(1, 1'b1, 32'd1, 32'd1, ALU_OP_ADD);
    tick();
    req1_valid = 1'b0;
    tick();

    // 3. Contention
    set_req(0, 1'b1, 32'd9, 32'd9, ALU_OP_SUB);
    set_req(1, 1'b1, 32'd1, 32'd2, ALU_OP_ADD);
    #2;
    chk("cont_req0_ready", 64'(req0_ready), 64'd1);
    chk("cont_req1_ready", 64'(req1_ready), 64'd0);
    tick();
    chk("cont_first_id", 64'(rsp_id), 64'd0);
    chk("cont_first_data", 64'(rsp_data), 64'd0);
    chk("cont_first_zero", 64'(rsp_zero), 64'd1);
    tick();
    #2;
    chk("cont_req1_ready", 64'(req1_ready), 64'd1);
    tick();
    chk("cont_second_id", 64'(rsp_id), 64'd1);
    chk("cont_second_data", 64'(rsp_data), 64'd3);
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      chk("alt_grant_id", 64'(rsp_id), 64'(k % 2));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // 4. Backpressure
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd20, ALU_OP_ADD);
    set_req(1, 1'b1, 32'd4, 32'd4, ALU_OP_ADD);
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_rsp_data", 64'(rsp_data), 64'd30);
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #2;
    chk("bp_req1_ready_acc", 64'(req1_ready), 64'd0);
    tick();
    #2;
    chk("bp_req1_grant", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    chk("bp_req1_data", 64'(rsp_data), 64'd8);
    tick();

    // 5. Illegal opcode, SUB underflow, counter wrap
    set_req(0, 1'b1, 32'd3, 32'd4, 6'b000000);
    tick();
    req0_valid = 1'b0;
    chk("ill_data", 64'(rsp_data), 64'd0);
    chk("ill_zero", 64'(rsp_zero), 64'd1);
    chk("ill_err", 64'(rsp_err), 64'd1);
    tick();
    set_req(1, 1'b1, 32'd0, 32'd1, ALU_OP_SUB);
    tick();
    req1_valid = 1'b0;
    chk("sub_data", 64'(rsp_data), 64'hFFFF_FFFF);
    chk("sub_zero", 64'(rsp_zero), 64'd0);
    chk("sub_err", 64'(rsp_err), 64'd0);
    tick();
    set_req(0, 1'b1, 32'd2, 32'd2, ALU_OP_ADD);
    guard = 0;
    while (op_count != {CW{1'b1}} && guard < 1000) begin
      tick();
      guard++;
    end
    chk("wrap_reach_max", 64'(op_count), 64'({CW{1'b1}}));
    tick();
    req0_valid = 1'b0;
    tick();
    chk("wrap_zero", 64'(op_count), 64'd0);
    set_req(0, 1'b1, 32'd2, 32'd2, ALU_OP_ADD);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("post_wrap_count", 64'(op_count), 64'd1);

    // 6. Reset while a response is pending
    set_req(0, 1'b1, 32'd6, 32'd1, ALU_OP_ADD);
    tick();
    req0_valid = 1'b0;
    chk("mid_rsp_valid_pre", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_op_count", 64'(op_count), 64'd0);
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_OP_ADD);
    set_req(1, 1'b1, 32'd1, 32'd1, ALU_OP_ADD);
    #2;
    chk("post_rst_req0_ready", 64'(req0_ready), 64'd1);
    chk("post_rst_req1_ready", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        logic [5:0]   op;
        logic [W-1:0] a, b;
        case ($urandom % 4)
          0, 1:    op = ALU_OP_ADD;
          2:       op = ALU_OP_SUB;
          default: op = 6'($urandom);
        endcase
        a = ($urandom % 2) ? W'($urandom_range(0, 3)) : W'($urandom);
        b = ($urandom % 2) ? W'($urandom_range(0, 3)) : W'($urandom);
        set_req(n, 1'($urandom % 2), a, b, op);
      end
      rsp_ready = ($urandom % 10) < 7;
      tick();
    end

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
